// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared types and constants for the two-port memory arbiter.
//   - state_e          : arbiter FSM states
//   - PORT_CONTROLLER  : port index of the controller (port 0)
//   - PORT_CORE        : port index of the processor under test (port 1)
//   - NUM_LANES        : byte lanes per memory word
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_RMW_READ,
      S_WRITE,
      S_RESP
   } state_e;

   localparam logic PORT_CONTROLLER = 1'b0;
   localparam logic PORT_CORE       = 1'b1;

   localparam int NUM_LANES  = 4;
   localparam int LANE_WIDTH = 8;
   localparam int WORD_WIDTH = NUM_LANES * LANE_WIDTH;

   localparam logic [NUM_LANES-1:0] BE_NONE = '0;
   localparam logic [NUM_LANES-1:0] BE_FULL = '1;

endpackage

// File: rtl/byte_lane_merge.sv
// ---------------------------------------------------------------------------
// byte_lane_merge
//   Combinational lane merge for read-modify-write: every lane whose mask
//   bit is set comes from the new word, the rest from the old word.
//   Ports:
//     old_word_i : word currently held in memory
//     new_word_i : word supplied by the requestor
//     mask_i     : lane enables, bit i selects bits 8i+7:8i of new_word_i
//     merged_o   : resulting word to write back
// ---------------------------------------------------------------------------
module byte_lane_merge
   import memory_arbiter_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] old_word_i,
   input  logic [WORD_WIDTH-1:0] new_word_i,
   input  logic [NUM_LANES-1:0]  mask_i,
   output logic [WORD_WIDTH-1:0] merged_o
);

   always_comb begin
      // NOTE: assign every always_comb output a default before any
      // conditional update; a path that leaves it unassigned infers a latch.
      merged_o = old_word_i;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mask_i[i]) begin
            merged_o[LANE_WIDTH*i +: LANE_WIDTH] = new_word_i[LANE_WIDTH*i +: LANE_WIDTH];
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Two-port arbiter in front of a single-ported, whole-word memory.
//   Services one request at a time, round-robin (or port 0 first when
//   FIXED_PRIORITY=1), and emulates byte-enable writes by read-modify-write.
//   Ports:
//     clk, reset                  : clock, synchronous active-high reset
//     pN_read / pN_write          : request strobes (write wins over read)
//     pN_address                  : byte address
//     pN_write_data, pN_byte_enable : write word and lane mask
//     pN_read_data                : registered read word, held between reads
//     pN_response                 : one-cycle completion pulse
//     mem_read / mem_write        : memory strobes, never both high
//     mem_address                 : word-aligned address to memory
//     mem_write_data              : word written to memory
//     mem_read_data, mem_response : memory return path
// ---------------------------------------------------------------------------
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     p0_read,
   input  logic                     p0_write,
   input  logic [ADDRESS_WIDTH-1:0] p0_address,
   input  logic [WORD_WIDTH-1:0]    p0_write_data,
   input  logic [NUM_LANES-1:0]     p0_byte_enable,
   output logic [WORD_WIDTH-1:0]    p0_read_data,
   output logic                     p0_response,
   input  logic                     p1_read,
   input  logic                     p1_write,
   input  logic [ADDRESS_WIDTH-1:0] p1_address,
   input  logic [WORD_WIDTH-1:0]    p1_write_data,
   input  logic [NUM_LANES-1:0]     p1_byte_enable,
   output logic [WORD_WIDTH-1:0]    p1_read_data,
   output logic                     p1_response,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [WORD_WIDTH-1:0]    mem_write_data,
   input  logic [WORD_WIDTH-1:0]    mem_read_data,
   input  logic                     mem_response
);

   localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~ADDRESS_WIDTH'(3);

   state_e                   state_q;
   logic                     grant_q;
   logic                     last_grant_q;
   logic [NUM_LANES-1:0]     be_q;
   logic                     mem_read_q;
   logic                     mem_write_q;
   logic [ADDRESS_WIDTH-1:0] mem_address_q;
   logic [WORD_WIDTH-1:0]    mem_write_data_q;
   logic [WORD_WIDTH-1:0]    p0_read_data_q;
   logic [WORD_WIDTH-1:0]    p1_read_data_q;
   logic                     p0_response_q;
   logic                     p1_response_q;

   logic                     p0_req;
   logic                     p1_req;
   logic                     sel;
   logic                     sel_write;
   logic [ADDRESS_WIDTH-1:0] sel_address;
   logic [WORD_WIDTH-1:0]    sel_write_data;
   logic [NUM_LANES-1:0]     sel_be;
   logic [WORD_WIDTH-1:0]    merged_word;

   // Winner selection for the IDLE cycle; last_grant_q breaks ties.
   always_comb begin
      p0_req = p0_read | p0_write;
      p1_req = p1_read | p1_write;
      if (p0_req && p1_req) begin
         sel = FIXED_PRIORITY ? PORT_CONTROLLER : ~last_grant_q;
      end else begin
         sel = p1_req ? PORT_CORE : PORT_CONTROLLER;
      end
      sel_write      = (sel == PORT_CORE) ? p1_write       : p0_write;
      sel_address    = (sel == PORT_CORE) ? p1_address     : p0_address;
      sel_write_data = (sel == PORT_CORE) ? p1_write_data  : p0_write_data;
      sel_be         = (sel == PORT_CORE) ? p1_byte_enable : p0_byte_enable;
   end

   // The latched write word doubles as the "new" side of the merge.
   byte_lane_merge u_merge (
      .old_word_i (mem_read_data),
      .new_word_i (mem_write_data_q),
      .mask_i     (be_q),
      .merged_o   (merged_word)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q          <= S_IDLE;
         grant_q          <= PORT_CONTROLLER;
         last_grant_q     <= PORT_CORE;
         be_q             <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         p0_read_data_q   <= '0;
         p1_read_data_q   <= '0;
         p0_response_q    <= 1'b0;
         p1_response_q    <= 1'b0;
      end else begin
         // Response pulses last exactly one cycle unless re-armed below.
         p0_response_q <= 1'b0;
         p1_response_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (p0_req || p1_req) begin
                  grant_q          <= sel;
                  last_grant_q     <= sel;
                  mem_address_q    <= sel_address & WORD_MASK;
                  mem_write_data_q <= sel_write_data;
                  be_q             <= sel_be;
                  if (!sel_write) begin
                     mem_read_q <= 1'b1;
                     state_q    <= S_READ;
                  end else if (sel_be == BE_FULL) begin
                     mem_write_q <= 1'b1;
                     state_q     <= S_WRITE;
                  end else if (sel_be == BE_NONE) begin
                     // Nothing to write: complete without touching memory.
                     if (sel == PORT_CORE) p1_response_q <= 1'b1;
                     else                  p0_response_q <= 1'b1;
                     state_q <= S_RESP;
                  end else begin
                     mem_read_q <= 1'b1;
                     state_q    <= S_RMW_READ;
                  end
               end
            end
            S_READ: begin
               if (mem_response) begin
                  mem_read_q <= 1'b0;
                  if (grant_q == PORT_CORE) begin
                     p1_read_data_q <= mem_read_data;
                     p1_response_q  <= 1'b1;
                  end else begin
                     p0_read_data_q <= mem_read_data;
                     p0_response_q  <= 1'b1;
                  end
                  state_q <= S_RESP;
               end
            end
            S_RMW_READ: begin
               if (mem_response) begin
                  mem_read_q       <= 1'b0;
                  mem_write_q      <= 1'b1;
                  mem_write_data_q <= merged_word;
                  state_q          <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (mem_response) begin
                  mem_write_q <= 1'b0;
                  if (grant_q == PORT_CORE) p1_response_q <= 1'b1;
                  else                      p0_response_q <= 1'b1;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign p0_read_data   = p0_read_data_q;
   assign p1_read_data   = p1_read_data_q;
   assign p0_response    = p0_response_q;
   assign p1_response    = p1_response_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;

endmodule
